// File: rtl/papuf_crp_driver.sv
// Challenge-side initiator for a pulse-activated PUF array: drives a challenge, fires
// N_SAMPLES activation pulses, majority-votes the synchronised responses and reports instability.
module papuf_crp_driver #(
  parameter int W          = 16,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int N_SAMPLES  = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_challenge,
  output logic [W-1:0] puf_challenge,
  output logic         puf_pulse,
  input  logic [W-1:0] puf_response,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] rsp_unstable,
  output logic         busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] PULSE  = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] SAMPLE = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int MAX_AB = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_PH = (MAX_AB > SETTLE_CYC) ? MAX_AB : SETTLE_CYC;
  localparam int CW     = $clog2(MAX_PH + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [3:0]    SAMPLE_LAST = 4'(N_SAMPLES - 1);
  localparam logic [3:0]    N_ALL       = 4'(N_SAMPLES);
  localparam logic [3:0]    N_HALF      = 4'(N_SAMPLES / 2);

  logic [2:0]          state;
  logic [CW-1:0]       phase_cnt;
  logic [3:0]          sample_cnt;
  logic [W-1:0][3:0]   ones;
  logic [W-1:0][3:0]   ones_next;
  logic [W-1:0]        vote_data;
  logic [W-1:0]        vote_unstable;
  logic [W-1:0]        sync1;
  logic [W-1:0]        sync2;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Two-flop synchroniser; the array outputs are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
    end
  end

  // Vote includes the sample being taken this cycle so the result can be registered on entry to DONE.
  always_comb begin
    ones_next     = '0;
    vote_data     = '0;
    vote_unstable = '0;
    for (int i = 0; i < W; i++) begin
      ones_next[i]     = ones[i] + {3'b000, sync2[i]};
      vote_data[i]     = (ones_next[i] > N_HALF);
      vote_unstable[i] = (ones_next[i] != 4'd0) && (ones_next[i] != N_ALL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      sample_cnt    <= '0;
      ones          <= '0;
      puf_challenge <= '0;
      puf_pulse     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_unstable  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            puf_challenge <= req_challenge;
            ones          <= '0;
            sample_cnt    <= '0;
            phase_cnt     <= '0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            phase_cnt <= '0;
            puf_pulse <= 1'b1;
            state     <= PULSE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        PULSE: begin
          if (phase_cnt == PULSE_LAST) begin
            phase_cnt <= '0;
            puf_pulse <= 1'b0;
            state     <= SETTLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            phase_cnt <= '0;
            state     <= SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          ones       <= ones_next;
          sample_cnt <= sample_cnt + 1'b1;
          if (sample_cnt == SAMPLE_LAST) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= vote_data;
            rsp_unstable <= vote_unstable;
            state        <= DONE;
          end else begin
            state <= SETUP;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
